lb2axil: RTL and testbench

LB2AXIL -- requirements
Module: lb2axil

---
 rtl/lb2axil.sv | 168 ++++++++++++++++
 tb/tb_lb2axil.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb2axil.sv
`default_nettype none
// ======================================================================
// lb2axil : local-bus request/pulse interface to AXI4-Lite master bridge
// Revision 1.0 - initial release
// ======================================================================
module lb2axil #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W/8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic              wready,
    output logic              werr,

    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rerr,

    output logic [ADDR_W-1:0] axil_awaddr,
    output logic [2:0]        axil_awprot,
    output logic              axil_awvalid,
    input  logic              axil_awready,
    output logic [DATA_W-1:0] axil_wdata,
    output logic [STRB_W-1:0] axil_wstrb,
    output logic              axil_wvalid,
    input  logic              axil_wready,
    input  logic [1:0]        axil_bresp,
    input  logic              axil_bvalid,
    output logic              axil_bready,
    output logic [ADDR_W-1:0] axil_araddr,
    output logic [2:0]        axil_arprot,
    output logic              axil_arvalid,
    input  logic              axil_arready,
    input  logic [DATA_W-1:0] axil_rdata,
    input  logic [1:0]        axil_rresp,
    input  logic              axil_rvalid,
    output logic              axil_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        WR_DONE = 3'd3,
        RD_REQ  = 3'd4,
        RD_RESP = 3'd5,
        RD_DONE = 3'd6
    } state_t;

    state_t            state;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic              aw_done;
    logic              w_done;

    assign axil_awprot = 3'b000;
    assign axil_arprot = 3'b000;
    // rd_addr cannot change while rd_pend is set, so it doubles as the AR payload
    assign axil_araddr = rd_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rd_pend      <= 1'b0;
            rd_addr      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            axil_awaddr  <= '0;
            axil_awvalid <= 1'b0;
            axil_wdata   <= '0;
            axil_wstrb   <= '0;
            axil_wvalid  <= 1'b0;
            axil_bready  <= 1'b0;
            axil_arvalid <= 1'b0;
            axil_rready  <= 1'b0;
            wready       <= 1'b0;
            werr         <= 1'b0;
            rvalid       <= 1'b0;
            rerr         <= 1'b0;
            rdata        <= '0;
        end else begin
            if (ren && !rd_pend) begin
                rd_pend <= 1'b1;
                rd_addr <= raddr;
            end

            case (state)
                IDLE: begin
                    if (wen) begin
                        axil_awaddr  <= waddr;
                        axil_wdata   <= wdata;
                        axil_wstrb   <= wstrb;
                        axil_awvalid <= 1'b1;
                        axil_wvalid  <= 1'b1;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        state        <= WR_REQ;
                    end else if (rd_pend) begin
                        axil_arvalid <= 1'b1;
                        state        <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (axil_awvalid && axil_awready) begin
                        axil_awvalid <= 1'b0;
                        aw_done      <= 1'b1;
                    end
                    if (axil_wvalid && axil_wready) begin
                        axil_wvalid <= 1'b0;
                        w_done      <= 1'b1;
                    end
                    if (aw_done && w_done) begin
                        axil_bready <= 1'b1;
                        state       <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axil_bvalid) begin
                        axil_bready <= 1'b0;
                        wready      <= 1'b1;
                        werr        <= (axil_bresp != 2'b00);
                        state       <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    // the requester still holds wen here; leaving unconditionally keeps it from re-firing
                    wready <= 1'b0;
                    werr   <= 1'b0;
                    state  <= IDLE;
                end
                RD_REQ: begin
                    if (axil_arready) begin
                        axil_arvalid <= 1'b0;
                        axil_rready  <= 1'b1;
                        state        <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axil_rvalid) begin
                        axil_rready <= 1'b0;
                        rd_pend     <= 1'b0;
                        rdata       <= axil_rdata;
                        rvalid      <= 1'b1;
                        rerr        <= (axil_rresp != 2'b00);
                        state       <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    rvalid <= 1'b0;
                    rerr   <= 1'b0;
                    rdata  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lb2axil.sv
`default_nettype none
// ======================================================================
// tb_lb2axil : vector table plus scoreboarded AXI4-Lite slave model
// Revision 1.0 - initial release
// ======================================================================
module tb_lb2axil;

    logic        clk;
    logic        rst;
    logic        wen, ren;
    logic [15:0] waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready, werr, rvalid, rerr;
    logic [31:0] rdata;

    logic [15:0] axil_awaddr, axil_araddr;
    logic [2:0]  axil_awprot, axil_arprot;
    logic        axil_awvalid, axil_awready, axil_wvalid, axil_wready;
    logic [31:0] axil_wdata, axil_rdata;
    logic [3:0]  axil_wstrb;
    logic [1:0]  axil_bresp, axil_rresp;
    logic        axil_bvalid, axil_bready, axil_arvalid, axil_arready;
    logic        axil_rvalid, axil_rready;

    lb2axil #(.ADDR_W(16), .DATA_W(32), .STRB_W(4)) dut (
        .clk(clk), .rst(rst),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .wready(wready), .werr(werr),
        .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .rerr(rerr),
        .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
        .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
        .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
        .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
        .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
        .axil_araddr(axil_araddr), .axil_arprot(axil_arprot),
        .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
        .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
        .axil_rvalid(axil_rvalid), .axil_rready(axil_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave configuration, driven by the stimulus process
    int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_resp = 2'b00;

    int   aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got;
    logic aw_hs, w_hs, ar_hs;

    assign axil_awready = axil_awvalid && (aw_cnt >= cfg_aw_wait);
    assign axil_wready  = axil_wvalid  && (w_cnt  >= cfg_w_wait);
    assign axil_arready = axil_arvalid && (ar_cnt >= cfg_ar_wait);
    assign aw_hs = axil_awvalid && axil_awready;
    assign w_hs  = axil_wvalid  && axil_wready;
    assign ar_hs = axil_arvalid && axil_arready;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            axil_bvalid <= 1'b0; axil_bresp <= 2'b00;
            axil_rvalid <= 1'b0; axil_rresp <= 2'b00; axil_rdata <= '0;
        end else begin
            if (axil_awvalid && !axil_awready) aw_cnt <= aw_cnt + 1; else if (aw_hs) aw_cnt <= 0;
            if (axil_wvalid  && !axil_wready)  w_cnt  <= w_cnt + 1;  else if (w_hs)  w_cnt  <= 0;
            if (axil_arvalid && !axil_arready) ar_cnt <= ar_cnt + 1; else if (ar_hs) ar_cnt <= 0;

            if (axil_bvalid && axil_bready) begin
                axil_bvalid <= 1'b0;
            end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                axil_bvalid <= 1'b1;
                axil_bresp  <= cfg_resp;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end

            if (axil_rvalid && axil_rready) begin
                axil_rvalid <= 1'b0;
            end else if (ar_hs) begin
                if (cfg_r_wait == 0) begin
                    axil_rvalid <= 1'b1; axil_rdata <= cfg_rdata; axil_rresp <= cfg_resp;
                end else begin
                    r_cnt <= cfg_r_wait;
                end
            end else if (r_cnt != 0) begin
                if (r_cnt == 1) begin
                    axil_rvalid <= 1'b1; axil_rdata <= cfg_rdata; axil_rresp <= cfg_resp;
                end
                r_cnt <= r_cnt - 1;
            end
        end
    end

    typedef struct packed { logic [31:0] d; logic [3:0] s; } wbeat_t;
    typedef struct packed { logic [31:0] d; logic e; } rres_t;
    logic [15:0] q_aw[$];
    wbeat_t      q_w[$];
    logic        q_b[$];
    logic [15:0] q_ar[$];
    rres_t       q_r[$];

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor state and statistics
    logic        p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0, p_wready = 1'b0, p_rvalid = 1'b0;
    logic [15:0] p_awaddr = '0, p_araddr = '0;
    logic [35:0] p_wbeat = '0;
    int awv_n = 0, wv_n = 0, arv_n = 0;
    int aw_cyc = 0, ar_cyc = 0, wr_cyc = 0, rv_cyc = 0;

    task automatic monitor();
        rres_t  r;
        wbeat_t b;
        logic   e;
        if (!rst) begin
            p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0; p_wready = 1'b0; p_rvalid = 1'b0;
            return;
        end
        if (p_awv) chk("aw_hold", 64'({axil_awvalid, axil_awaddr}), 64'({1'b1, p_awaddr}));
        if (p_wv)  chk("w_hold",  64'({axil_wvalid, axil_wdata, axil_wstrb}), 64'({1'b1, p_wbeat}));
        if (p_arv) chk("ar_hold", 64'({axil_arvalid, axil_araddr}), 64'({1'b1, p_araddr}));
        p_awv = axil_awvalid && !axil_awready; p_awaddr = axil_awaddr;
        p_wv  = axil_wvalid  && !axil_wready;  p_wbeat  = {axil_wdata, axil_wstrb};
        p_arv = axil_arvalid && !axil_arready; p_araddr = axil_araddr;
        if (axil_awvalid) awv_n++;
        if (axil_wvalid)  wv_n++;
        if (axil_arvalid) arv_n++;

        chk("one_outstanding", 64'((axil_awvalid || axil_wvalid || axil_bready) &&
                                   (axil_arvalid || axil_rready)), 64'(0));

        if (aw_hs) begin
            aw_cyc = cyc;
            chk("awprot", 64'(axil_awprot), 64'(0));
            if (q_aw.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
            else chk("awaddr", 64'(axil_awaddr), 64'(q_aw.pop_front()));
        end
        if (w_hs) begin
            if (q_w.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
            else begin
                b = q_w.pop_front();
                chk("wdata", 64'(axil_wdata), 64'(b.d));
                chk("wstrb", 64'(axil_wstrb), 64'(b.s));
            end
        end
        if (ar_hs) begin
            ar_cyc = cyc;
            chk("arprot", 64'(axil_arprot), 64'(0));
            if (q_ar.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
            else chk("araddr", 64'(axil_araddr), 64'(q_ar.pop_front()));
        end
        if (wready) begin
            wr_cyc = cyc;
            chk("wready_pulse", 64'(p_wready), 64'(0));
            if (q_b.size() == 0) chk("wready_unexpected", 64'(1), 64'(0));
            else begin
                e = q_b.pop_front();
                chk("werr", 64'(werr), 64'(e));
            end
        end else begin
            chk("werr_idle", 64'(werr), 64'(0));
        end
        if (rvalid) begin
            rv_cyc = cyc;
            chk("rvalid_pulse", 64'(p_rvalid), 64'(0));
            if (q_r.size() == 0) chk("rvalid_unexpected", 64'(1), 64'(0));
            else begin
                r = q_r.pop_front();
                chk("rdata", 64'(rdata), 64'(r.d));
                chk("rerr", 64'(rerr), 64'(r.e));
            end
        end else begin
            chk("rerr_idle", 64'(rerr), 64'(0));
            if (p_rvalid) chk("rdata_clear", 64'(rdata), 64'(0));
        end
        p_wready = wready;
        p_rvalid = rvalid;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_w, w_w, ar_w, r_w;
        logic [1:0]  resp;
        logic        exp_err;
        int          exp_lat;
        int          exp_v1;   // awvalid (write) or arvalid (read) cycles
        int          exp_v2;   // wvalid cycles
    } vec_t;

    task automatic run_vec(input vec_t v);
        int  start, a0, w0, lat;
        bit  done;
        cfg_aw_wait = v.aw_w; cfg_w_wait = v.w_w; cfg_ar_wait = v.ar_w; cfg_r_wait = v.r_w;
        cfg_rdata = v.data; cfg_resp = v.resp;
        @(negedge clk);
        a0 = v.wr ? awv_n : arv_n;
        w0 = wv_n;
        if (v.wr) begin
            wen = 1'b1; waddr = v.addr; wdata = v.data; wstrb = v.strb;
            q_aw.push_back(v.addr); q_w.push_back({v.data, v.strb}); q_b.push_back(v.exp_err);
        end else begin
            ren = 1'b1; raddr = v.addr;
            q_ar.push_back(v.addr); q_r.push_back({v.data, v.exp_err});
        end
        start = cyc;
        lat = 0;
        @(posedge clk); #1 ren = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (v.wr ? wready : rvalid) begin
                done = 1'b1;
                lat = cyc - start;
            end
        end
        if (!done) chk("complete_timeout", 64'(1), 64'(0));
        else chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("addr_valid_cycles", 64'((v.wr ? awv_n : arv_n) - a0), 64'(v.exp_v1));
        if (v.wr) begin
            chk("wvalid_cycles", 64'(wv_n - w0), 64'(v.exp_v2));
            @(posedge clk); #1 wen = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[9];

    initial begin
        bit done;
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wstrb = '0;

        //                wr  addr      data          strb  aw w ar r resp  err lat v1 v2
        vecs[0] = '{1'b1, 16'h0004, 32'hdeadbeef, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0, 4, 1, 1};
        vecs[1] = '{1'b1, 16'h0010, 32'h12345678, 4'h6, 5, 0, 0, 0, 2'b00, 1'b0, 9, 6, 1};
        vecs[2] = '{1'b0, 16'h0014, 32'hc0debabe, 4'h0, 0, 0, 0, 5, 2'b00, 1'b0, 9, 1, 0};
        vecs[3] = '{1'b1, 16'h0020, 32'ha5a5a5a5, 4'hF, 0, 0, 0, 0, 2'b10, 1'b1, 4, 1, 1};
        vecs[4] = '{1'b0, 16'h0024, 32'h0badf00d, 4'h0, 0, 0, 0, 0, 2'b11, 1'b1, 4, 1, 0};
        vecs[5] = '{1'b1, 16'h0030, 32'h55aa33cc, 4'h9, 0, 3, 0, 0, 2'b00, 1'b0, 7, 1, 4};
        vecs[6] = '{1'b0, 16'h0038, 32'h13579bdf, 4'h0, 0, 0, 2, 0, 2'b00, 1'b0, 6, 3, 0};
        vecs[7] = '{1'b0, 16'h003c, 32'hffffffff, 4'h0, 0, 0, 0, 0, 2'b01, 1'b1, 4, 1, 0};
        vecs[8] = '{1'b1, 16'hfffc, 32'h00000000, 4'h0, 0, 0, 0, 0, 2'b00, 1'b0, 4, 1, 1};

        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 64'(axil_awvalid), 64'(0));
        chk("rst_wvalid",  64'(axil_wvalid),  64'(0));
        chk("rst_bready",  64'(axil_bready),  64'(0));
        chk("rst_arvalid", 64'(axil_arvalid), 64'(0));
        chk("rst_rready",  64'(axil_rready),  64'(0));
        chk("rst_wready",  64'(wready), 64'(0));
        chk("rst_rvalid",  64'(rvalid), 64'(0));
        chk("rst_rdata",   64'(rdata),  64'(0));
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // write and read requested in the same cycle
        cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_r_wait = 0;
        cfg_rdata = 32'h87654321; cfg_resp = 2'b00;
        @(negedge clk);
        wen = 1'b1; waddr = 16'h000c; wdata = 32'hcafef00d; wstrb = 4'hF;
        ren = 1'b1; raddr = 16'h0008;
        q_aw.push_back(16'h000c); q_w.push_back({32'hcafef00d, 4'hF}); q_b.push_back(1'b0);
        q_ar.push_back(16'h0008); q_r.push_back({32'h87654321, 1'b0});
        @(posedge clk); #1 ren = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (wready) begin
                @(posedge clk); #1 wen = 1'b0;
            end
            if (rvalid) done = 1'b1;
        end
        if (!done) chk("dual_timeout", 64'(1), 64'(0));
        chk("aw_before_ar", 64'(aw_cyc < ar_cyc), 64'(1));
        chk("wready_before_rvalid", 64'(wr_cyc < rv_cyc), 64'(1));
        repeat (2) @(negedge clk);

        // reset while AWVALID is held by a stalled slave
        cfg_aw_wait = 10;
        @(negedge clk);
        wen = 1'b1; waddr = 16'h0040; wdata = 32'h11112222; wstrb = 4'hF;
        q_aw.push_back(16'h0040); q_w.push_back({32'h11112222, 4'hF}); q_b.push_back(1'b0);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (axil_awvalid) done = 1'b1;
        end
        if (!done) chk("awvalid_timeout", 64'(1), 64'(0));
        #2 rst = 1'b0;
        #1;
        chk("arst_awvalid", 64'(axil_awvalid), 64'(0));
        chk("arst_wvalid",  64'(axil_wvalid),  64'(0));
        chk("arst_bready",  64'(axil_bready),  64'(0));
        chk("arst_arvalid", 64'(axil_arvalid), 64'(0));
        chk("arst_rready",  64'(axil_rready),  64'(0));
        chk("arst_wready",  64'(wready), 64'(0));
        chk("arst_rvalid",  64'(rvalid), 64'(0));
        wen = 1'b0;
        q_aw.delete(); q_w.delete(); q_b.delete(); q_ar.delete(); q_r.delete();
        cfg_aw_wait = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run_vec(vecs[0]);

        chk("scoreboard_empty",
            64'(q_aw.size() + q_w.size() + q_b.size() + q_ar.size() + q_r.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
